// File: rtl/matrix_cps_pkg.sv
// Shared types for the matrix compute path: per-tile array control,
// the input skewer FSM states and the flush-length helper.
package matrix_cps_pkg;

    typedef struct packed {
        logic [2:0] datatype;
        logic       is_float;
    } sa_ctrl_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skewer_state_e;

    // Zero-filled beats after the last real beat until the far PE has consumed it.
    function automatic int flush_len(input int n_rows, input int n_cols);
        return n_rows + n_cols - 2;
    endfunction

endpackage

// File: rtl/sa_lane_delay.sv
// Enabled shift register of DEPTH stages carrying one lane's data and valid;
// DEPTH=0 degenerates to a wire.
module sa_lane_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_ni, en_i};
        assign q_o = d_i;
        assign v_o = v_i;
    end else begin : g_shift
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [DEPTH-1:0] vld_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
                vld_q <= '0;
            end else if (en_i) begin
                data_q[0] <= d_i;
                vld_q[0]  <= v_i;
                for (int i = 1; i < DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
            end
        end

        assign q_o = data_q[DEPTH-1];
        assign v_o = vld_q[DEPTH-1];
    end

endmodule

// File: rtl/sa_input_skewer.sv
// Left-edge feeder of the systolic array: delays lane r by r pump beats,
// drives the pump strobe and tile control, and flushes zeros after the last beat.
module sa_input_skewer
    import matrix_cps_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         last_i,
    input  logic [N_ROWS*DATA_WIDTH-1:0] data_i,
    input  sa_ctrl_t                     sa_ctrl_i,
    input  logic                         stall_i,
    output logic                         pump_o,
    output logic [N_ROWS*DATA_WIDTH-1:0] data_o,
    output logic [N_ROWS-1:0]            lane_valid_o,
    output sa_ctrl_t                     sa_ctrl_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int FLUSH = flush_len(N_ROWS, N_COLS);
    localparam int CW    = (FLUSH > 0) ? $clog2(FLUSH + 1) : 1;

    skewer_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    sa_ctrl_t      ctrl_q, ctrl_d;
    logic          done_q, done_d;
    logic          accept, adv, in_vld;

    // Handshake: a beat transfers when valid_i and ready_o are both high in a cycle;
    // ready_o is low while stalled, while draining, and while reset is asserted.
    assign ready_o = rst_ni & ~stall_i & (state_q != DRAIN);
    assign accept  = valid_i & ready_o;
    assign adv     = accept | (rst_ni & ~stall_i & (state_q == DRAIN));
    assign in_vld  = rst_ni & valid_i & (state_q != DRAIN);

    assign pump_o    = adv;
    assign sa_ctrl_o = ctrl_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctrl_d  = sa_ctrl_i;
                    state_d = STREAM;
                    if (last_i) begin
                        if (FLUSH == 0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = CW'(FLUSH);
                        end
                    end
                end
            end
            STREAM: begin
                if (accept && last_i) begin
                    if (FLUSH == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CW'(FLUSH);
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_lane
        sa_lane_delay #(
            .DEPTH(r),
            .WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .en_i  (adv),
            .d_i   (in_vld ? data_i[r*DATA_WIDTH +: DATA_WIDTH] : '0),
            .v_i   (in_vld),
            .q_o   (data_o[r*DATA_WIDTH +: DATA_WIDTH]),
            .v_o   (lane_valid_o[r])
        );
    end

endmodule
